// File: rtl/edge_threshold.sv
// edge_threshold
//   Thresholds a Sobel gradient-magnitude stream into a binary edge map, or
//   passes a grey pixel through, behind a one-deep registered output stage.
//   It also counts the edge pixels of each frame.
//
//   A flush request discards the rest of the current frame. Output then
//   resumes at the next start-of-frame beat. After reset the block sits in
//   the flush state, so only whole frames are ever emitted.
//
// Parameters
//   MAG_W     gradient-magnitude width
//   SCALE_SH  left shift applied to i_threshold before comparison
//   CNT_W     edge-counter width (saturating)
//
// Ports
//   i_sysclk               clock
//   RST                    asynchronous active-low reset
//   i_mode                 0 = passthrough, 1 = filter
//   i_sobel_en             thresholding enable (filter needs both)
//   i_flush                flush request, level; acts on its rising edge
//   i_threshold[25:0]      unsigned threshold, latched per frame on sof
//   s_valid/s_ready        upstream handshake
//   s_sof, s_mag, s_pix    upstream beat payload
//   m_valid/m_ready        downstream handshake
//   m_sof, m_pix           downstream beat payload
//   o_edge_count           edge pixels of the last completed frame
//   o_count_valid          one-cycle strobe when o_edge_count updates
module edge_threshold #(
  parameter int MAG_W    = 11,
  parameter int SCALE_SH = 3,
  parameter int CNT_W    = 20
) (
  input  logic             i_sysclk,
  input  logic             RST,
  input  logic             i_mode,
  input  logic             i_sobel_en,
  input  logic             i_flush,
  input  logic [25:0]      i_threshold,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [MAG_W-1:0] s_mag,
  input  logic [7:0]       s_pix,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic [7:0]       m_pix,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_count_valid
);

  localparam int CMP_W = 26 + SCALE_SH;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  logic             flush_q;
  logic             flush_rise;
  logic [25:0]      thr_q;
  logic [25:0]      thr_used;
  logic [CMP_W-1:0] thr_scaled;
  logic [CMP_W-1:0] mag_ext;
  logic             filter_on;
  logic             above;
  logic             is_edge;
  logic [7:0]       pix_d;
  logic             out_free;
  logic             accept;
  logic             take;
  logic [CNT_W-1:0] run_cnt;

  // ---------------------------------------------------------------------
  // Handshake and beat qualification
  // ---------------------------------------------------------------------
  assign flush_rise = i_flush & ~flush_q;
  assign out_free   = ~m_valid | m_ready;

  // While flushing, non-sof beats are sunk unconditionally. A sof beat
  // produces output, so it must wait for the output stage like in RUN.
  always_comb begin
    s_ready = 1'b1;
    if (state_q == RUN || s_sof) begin
      s_ready = out_free;
    end
  end

  assign accept = s_valid & s_ready;
  assign take   = accept & ((state_q == RUN) | s_sof);

  // ---------------------------------------------------------------------
  // Thresholding datapath
  // ---------------------------------------------------------------------
  // The sof beat already uses the new threshold, before thr_q captures it.
  assign thr_used   = s_sof ? i_threshold : thr_q;
  assign thr_scaled = CMP_W'(thr_used) << SCALE_SH;
  assign mag_ext    = CMP_W'(s_mag);
  assign above      = mag_ext > thr_scaled;
  assign filter_on  = i_mode & i_sobel_en;
  assign is_edge    = filter_on & above;

  always_comb begin
    pix_d = s_pix;
    if (filter_on) begin
      pix_d = above ? 8'hFF : 8'h00;
    end
  end

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  // An accepted sof beat wins over a coincident flush edge, so a flush
  // that lines up with a frame start does not drop the new frame.
  always_comb begin
    state_d = state_q;
    if (take && s_sof) begin
      state_d = RUN;
    end else if (state_q == RUN && flush_rise) begin
      state_d = FLUSH;
    end
  end

  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      state_q <= FLUSH;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= i_flush;
    end
  end

  // ---------------------------------------------------------------------
  // Output register: loads on a taken beat, otherwise holds until drained
  // ---------------------------------------------------------------------
  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_pix   <= '0;
    end else if (take) begin
      m_valid <= 1'b1;
      m_sof   <= s_sof;
      m_pix   <= pix_d;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Threshold latch and per-frame edge counter
  // ---------------------------------------------------------------------
  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      thr_q         <= '0;
      run_cnt       <= '0;
      o_edge_count  <= '0;
      o_count_valid <= 1'b0;
    end else begin
      o_count_valid <= 1'b0;
      if (take) begin
        if (s_sof) begin
          thr_q         <= i_threshold;
          o_edge_count  <= run_cnt;
          o_count_valid <= 1'b1;
          run_cnt       <= is_edge ? CNT_W'(1) : '0;
        end else if (is_edge && run_cnt != '1) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold.sv
module tb_edge_threshold;

  localparam int MAG_W = 11;
  localparam int SH    = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             i_sysclk = 1'b0;
  logic             RST = 1'b0;
  logic             i_mode = 1'b0;
  logic             i_sobel_en = 1'b0;
  logic             i_flush = 1'b0;
  logic [25:0]      i_threshold = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             s_sof = 1'b0;
  logic [MAG_W-1:0] s_mag = '0;
  logic [7:0]       s_pix = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic             m_sof;
  logic [7:0]       m_pix;
  logic [CW-1:0]    o_edge_count;
  logic             o_count_valid;

  edge_threshold #(.MAG_W(MAG_W), .SCALE_SH(SH), .CNT_W(CW)) dut (
    .i_sysclk     (i_sysclk),
    .RST          (RST),
    .i_mode       (i_mode),
    .i_sobel_en   (i_sobel_en),
    .i_flush      (i_flush),
    .i_threshold  (i_threshold),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_sof        (s_sof),
    .s_mag        (s_mag),
    .s_pix        (s_pix),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sof        (m_sof),
    .m_pix        (m_pix),
    .o_edge_count (o_edge_count),
    .o_count_valid(o_count_valid)
  );

  always #5 i_sysclk = ~i_sysclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: frame-level rules, evaluated once per cycle at the
  // falling edge when all inputs are stable.
  // ------------------------------------------------------------------
  logic [8:0] expq[$];   // {sof, pix} of beats that must appear downstream
  int         cntq[$];   // frame edge counts that must be reported
  bit         in_frame;  // false = discarding until next sof
  bit         out_busy;  // an output beat is pending downstream
  bit         cv_exp;
  bit         fl_prev;
  longint     thr_frame;
  int         edges;
  int         out_seen = 0;
  bit         prev_hold;
  logic [8:0] prev_out;

  always @(negedge i_sysclk) begin
    if (!RST) begin
      expq.delete();
      cntq.delete();
      in_frame  = 0;
      out_busy  = 0;
      cv_exp    = 0;
      fl_prev   = 0;
      thr_frame = 0;
      edges     = 0;
      prev_hold = 0;
    end else begin
      bit         acc, edge_b, nxt_busy, rdy_exp;
      longint     thr;
      logic [7:0] px;

      chk("m_valid", m_valid, out_busy);
      if (prev_hold) chk("m_hold", {m_sof, m_pix}, prev_out);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("unexpected_out", 1, 0);
        else chk("m_beat", {m_sof, m_pix}, expq.pop_front());
        out_seen++;
      end
      chk("count_valid", o_count_valid, cv_exp);
      if (o_count_valid) begin
        if (cntq.size() == 0) chk("unexpected_count", 1, 0);
        else chk("edge_count", o_edge_count, cntq.pop_front());
      end

      // a beat headed for the output must find the output stage free
      rdy_exp = (in_frame || s_sof) ? (!out_busy || m_ready) : 1'b1;
      chk("s_ready", s_ready, rdy_exp);
      acc      = s_valid && rdy_exp;
      nxt_busy = out_busy && !m_ready;
      cv_exp   = 0;
      if (acc && (in_frame || s_sof)) begin
        thr    = s_sof ? longint'(i_threshold) : thr_frame;
        edge_b = i_mode && i_sobel_en && (longint'(s_mag) > thr * (1 << SH));
        px     = (i_mode && i_sobel_en) ? (edge_b ? 8'hFF : 8'h00) : s_pix;
        expq.push_back({s_sof, px});
        nxt_busy = 1;
        if (s_sof) begin
          cntq.push_back(edges > CMAX ? CMAX : edges);
          cv_exp    = 1;
          edges     = edge_b ? 1 : 0;
          thr_frame = longint'(i_threshold);
        end else if (edge_b) begin
          edges++;
        end
      end
      if (acc && s_sof) in_frame = 1;
      else if (in_frame && i_flush && !fl_prev) in_frame = 0;
      fl_prev   = i_flush;
      out_busy  = nxt_busy;
      prev_hold = m_valid && !m_ready;
      prev_out  = {m_sof, m_pix};
    end
  end

  // ------------------------------------------------------------------
  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
  // ------------------------------------------------------------------
  int mr_mode = 0;
  always @(posedge i_sysclk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom % 3) != 0;
      default: m_ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) @(posedge i_sysclk);
    #1;
  endtask

  task automatic send(input bit sof, input int mag, input logic [7:0] pix);
    int n = 0;
    s_valid = 1'b1;
    s_sof   = sof;
    s_mag   = MAG_W'(mag);
    s_pix   = pix;
    @(negedge i_sysclk);
    while (!s_ready && n < 50) begin
      @(negedge i_sysclk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(posedge i_sysclk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  initial begin
    int base;

    // reset state
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sof", m_sof, 0);
    chk("rst_m_pix", m_pix, 0);
    chk("rst_edge_count", o_edge_count, 0);
    chk("rst_count_valid", o_count_valid, 0);
    @(posedge i_sysclk);
    #1 RST = 1'b1;
    idle(2);

    // partial frame after reset is discarded, output starts at sof
    base = out_seen;
    i_mode = 0;
    for (int unsigned i = 0; i < 3; i++) send(0, 0, 8'(8'h10 + i));
    send(1, 0, 8'h5A);
    idle(3);
    chk("first_frame_beats", out_seen - base, 1);

    // threshold boundary and per-frame latching
    i_mode = 1; i_sobel_en = 1; i_threshold = 25;
    send(1, 200, 8'h11);
    send(0, 201, 8'h22);
    send(0, 200, 8'h33);
    i_threshold = 10;
    send(0, 100, 8'h44);
    send(0, 201, 8'h55);
    send(1, 100, 8'h66);   // new frame picks up threshold 10
    send(0, 81, 8'h00);
    send(0, 80, 8'h00);

    // frame with exactly 7 edges
    i_threshold = 25;
    send(1, 0, 8'h00);
    for (int unsigned i = 0; i < 7; i++) begin
      send(0, 300, 8'h00);
      send(0, 100, 8'h00);
    end
    send(1, 0, 8'h00);

    // 20 edges saturate the 4-bit counter
    for (int unsigned i = 0; i < 20; i++) send(0, 2047, 8'h00);
    send(1, 0, 8'h00);
    i_sobel_en = 0;
    send(0, 2047, 8'h77);   // passthrough, not an edge
    i_sobel_en = 1;

    // downstream stall: s_ready drops, output holds
    mr_mode = 2;
    idle(1);
    send(0, 2047, 8'h00);
    fork
      send(0, 0, 8'h00);
      begin idle(5); mr_mode = 0; end
    join
    idle(2);

    // flush mid-frame, held high through the next sof
    i_mode = 0;
    send(0, 0, 8'hA1);
    i_flush = 1;
    send(0, 0, 8'hA2);
    for (int unsigned i = 0; i < 3; i++) send(0, 0, 8'(8'hB0 + i));
    send(1, 0, 8'hC0);
    for (int unsigned i = 0; i < 3; i++) send(0, 0, 8'(8'hC1 + i));
    i_flush = 0;
    send(0, 0, 8'hC8);
    send(0, 0, 8'hC9);

    // reset with an output beat stuck in the register
    mr_mode = 2;
    idle(1);
    send(0, 0, 8'hD0);
    RST = 1'b0;
    idle(2);
    RST = 1'b1;
    mr_mode = 1;
    send(0, 0, 8'hD1);
    send(1, 0, 8'hD2);

    // random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      i_mode      = ($urandom % 4) != 0;
      i_sobel_en  = ($urandom % 4) != 0;
      i_threshold = 26'($urandom_range(0, 300));
      if (($urandom % 40) == 0) i_flush = ~i_flush;
      send(($urandom % 16) == 0, int'($urandom_range(0, 2047)), 8'($urandom));
      if (($urandom % 4) == 0) idle(int'($urandom_range(1, 3)));
    end

    mr_mode = 0;
    i_flush = 0;
    idle(5);
    chk("drain_beats", expq.size(), 0);
    chk("drain_counts", cntq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/edge_threshold.md
EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 SHALL have parameter MAG_W, default 11, Sobel gradient-magnitude width.
REQ-002 SHALL have parameter SCALE_SH, default 3; effective threshold = i_threshold << SCALE_SH.
REQ-003 SHALL have parameter CNT_W, default 20, edge-counter width.
REQ-004 SHALL have port i_sysclk  in  1  sole clock.
REQ-005 SHALL have port RST  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_mode  in  1  0 = passthrough, 1 = filter mode.
REQ-007 SHALL have port i_sobel_en  in  1  Sobel thresholding enable.
REQ-008 SHALL have port i_flush  in  1  pipeline flush request, level.
REQ-009 SHALL have port i_threshold  in  26  Sobel threshold, unsigned.
REQ-010 SHALL have port s_valid / s_ready  in / out  1 / 1  upstream handshake.
REQ-011 SHALL have port s_sof  in  1  first pixel of frame.
REQ-012 SHALL have port s_mag  in  MAG_W  gradient magnitude, unsigned.
REQ-013 SHALL have port s_pix  in  8  grey pixel for passthrough.
REQ-014 SHALL have port m_valid / m_ready  out / in  1 / 1  downstream handshake.
REQ-015 SHALL have port m_sof  out  1  frame start, aligned with m_pix.
REQ-016 SHALL have port m_pix  out  8  output pixel.
REQ-017 SHALL have port o_edge_count  out  CNT_W  edge pixels in last completed frame.
REQ-018 SHALL have port o_count_valid  out  1  one-cycle strobe on o_edge_count update.

Function
REQ-019 A beat SHALL transfer on s_valid&&s_ready; an output beat SHALL transfer on m_valid&&m_ready.
REQ-020 Once asserted, m_valid, m_sof and m_pix SHALL hold unchanged until m_ready.
REQ-021 State machine: RUN, FLUSH.
- RUN: s_ready = ~m_valid | m_ready.
- FLUSH: s_ready = 1.
REQ-022 RUN -> FLUSH SHALL occur on a registered rising edge of i_flush.
- A held-high i_flush SHALL NOT re-trigger.
REQ-023 FLUSH -> RUN SHALL occur on an accepted beat with s_sof=1.
- That beat SHALL be processed as in RUN.
- This beat has priority over a coincident i_flush rising edge.
REQ-024 In FLUSH, accepted non-sof beats SHALL be discarded: no output, not counted.
REQ-025 In FLUSH, a pending output beat SHALL still be held and delivered.
- If the output register is occupied, the sof beat SHALL wait (s_ready = ~m_valid | m_ready for sof).
REQ-026 On an accepted sof beat, the threshold register thr_q SHALL latch i_threshold.
- The latched value SHALL apply to that beat and to the rest of the frame.
REQ-027 Comparison SHALL be {s_mag zero-extended} > (thr_used << SCALE_SH), evaluated at 26+SCALE_SH bits with no truncation.
- thr_used = i_threshold on the sof beat, thr_q otherwise.
REQ-028 Output pixel selection:
- m_pix = s_pix if i_mode=0 or i_sobel_en=0.
- Otherwise m_pix = 8'hFF if compare true, else 8'h00.
REQ-029 Latency SHALL be 1 cycle: an accepted beat appears on m_* the next cycle.
REQ-030 Running counter SHALL increment per processed beat whose filter-mode result is 8'hFF.
- It SHALL saturate at all-ones.
REQ-031 On an accepted sof beat:
- o_edge_count <= running count (excluding this beat).
- Running count <= 1 if this beat is an edge, else 0.
- o_count_valid pulses 1 cycle.
REQ-032 i_mode and i_sobel_en changes SHALL take effect on the next accepted beat.

Reset
REQ-033 On RST low, the following SHALL clear asynchronously:
- state = FLUSH, thr_q = 0, running count = 0.
- m_valid = 0, m_sof = 0, m_pix = 0.
- o_edge_count = 0, o_count_valid = 0, flush edge register = 0.
REQ-034 After reset, output SHALL begin only at the first sof beat; partial frames SHALL be discarded.
REQ-035 Reset mid-frame SHALL drop the in-flight output beat.

Verification
REQ-036 Reset, then 3 non-sof beats and a sof beat with s_pix=8'h5A, i_mode=0 -> non-sof beats dropped; one output beat m_sof=1, m_pix=8'h5A one cycle later.
REQ-037 i_mode=1, i_sobel_en=1, i_threshold=25, SCALE_SH=3 -> s_mag=200 gives 8'h00; s_mag=201 gives 8'hFF; i_threshold changed mid-frame to 10 has no effect until next sof.
REQ-038 Frame with 7 edge beats, then sof -> o_edge_count=7, o_count_valid single-cycle pulse.
REQ-039 m_ready low 5 cycles with m_valid high -> s_ready low, m_* stable, no beat lost or duplicated.
REQ-040 i_flush rises mid-frame, stays high through next sof, falls after -> remaining beats dropped; output resumes at sof; no re-flush.
REQ-041 Counter CNT_W=4, 20 edges in one frame -> o_edge_count=15 at next sof.
